sprite_compositor: RTL and testbench

//  Parametrised N-layer pixel compositor for the Pac-Man video path; supersedes the single-tile 9-way sprite mux.

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_compositor_if.sv | 29 ++
 rtl/sprite_blink_timer.sv | 30 +++
 rtl/sprite_compositor.sv | 134 +++++++++++++
 tb/tb_sprite_compositor.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared tile-type codes and pixel constants for the sprite compositor.
package sprite_pkg;

  localparam int unsigned TILE_W          = 4;
  localparam int unsigned TRANSPARENT_PIX = 0;

  typedef enum logic [TILE_W-1:0] {
    SPACE        = 4'd0,
    POINT        = 4'd1,
    POWERBALL    = 4'd2,
    FRUIT        = 4'd3,
    EDIBLE_GHOST = 4'd4,
    PACMAN       = 4'd5,
    GHOST_GATE   = 4'd6,
    GHOST        = 4'd7,
    WALL         = 4'd8
  } tile_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Layer input / composited pixel output bundle of the sprite compositor.
interface sprite_compositor_if #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned PIX_W      = 2,
  parameter int unsigned SEL_W      = 4
);
  logic                        frame_tick;
  logic                        flash_en;
  logic                        mask_we;
  logic [NUM_LAYERS-1:0]       mask_wdata;
  logic                        pix_valid_in;
  logic [NUM_LAYERS*SEL_W-1:0] layer_type;
  logic [NUM_LAYERS*PIX_W-1:0] layer_pix;
  logic                        pix_valid_out;
  logic [PIX_W-1:0]            pix_out;
  logic [SEL_W-1:0]            type_out;
  logic                        hit_ghost;
  logic                        hit_edible;

  modport master (
    output frame_tick, flash_en, mask_we, mask_wdata, pix_valid_in, layer_type, layer_pix,
    input  pix_valid_out, pix_out, type_out, hit_ghost, hit_edible
  );

  modport slave (
    input  frame_tick, flash_en, mask_we, mask_wdata, pix_valid_in, layer_type, layer_pix,
    output pix_valid_out, pix_out, type_out, hit_ghost, hit_edible
  );
endinterface

// File: rtl/sprite_blink_timer.sv
// Frame counter producing the powerball blink / ghost flash phase.
module sprite_blink_timer #(
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  output logic blink_phase
);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (frame_tick) begin
      if (r_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign blink_phase = r_phase;
endmodule

// File: rtl/sprite_compositor.sv
// Two-stage N-layer pixel compositor: blink/flash/mask in stage 1, priority in stage 2,
// plus per-frame Pac-Man/ghost overlap reporting.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = 4,
  parameter int unsigned PIX_W        = 2,
  parameter int unsigned SEL_W        = TILE_W,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned FLASH_PIX    = 3
) (
  input logic                Clk,
  input logic                Reset,
  sprite_compositor_if.slave bus
);
  logic                        w_blink_phase;
  logic [NUM_LAYERS-1:0]       r_mask;
  logic [NUM_LAYERS-1:0]       w_opaque;
  logic [NUM_LAYERS*PIX_W-1:0] w_eff_pix;
  logic                        w_pac, w_ghost, w_edible;

  logic                        r_s1_valid;
  logic [NUM_LAYERS-1:0]       r_s1_opaque;
  logic [NUM_LAYERS*PIX_W-1:0] r_s1_pix;
  logic [NUM_LAYERS*SEL_W-1:0] r_s1_type;
  logic                        r_s1_pac, r_s1_ghost, r_s1_edible;

  logic [PIX_W-1:0]            w_win_pix;
  logic [SEL_W-1:0]            w_win_type;

  logic                        r_valid_out;
  logic [PIX_W-1:0]            r_pix_out;
  logic [SEL_W-1:0]            r_type_out;
  logic                        r_s2_hit_g, r_s2_hit_e;
  logic                        r_acc_g, r_acc_e, r_hit_g, r_hit_e;

  sprite_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (bus.frame_tick),
    .blink_phase(w_blink_phase)
  );

  // Stage-1 per-layer opacity, flash substitution and presence flags
  always_comb begin
    w_opaque  = '0;
    w_eff_pix = bus.layer_pix;
    w_pac     = 1'b0;
    w_ghost   = 1'b0;
    w_edible  = 1'b0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      w_opaque[i] = r_mask[i]
                 && (bus.layer_pix[i*PIX_W +: PIX_W] != PIX_W'(TRANSPARENT_PIX))
                 && (bus.layer_type[i*SEL_W +: SEL_W] != SEL_W'(SPACE))
                 && !((bus.layer_type[i*SEL_W +: SEL_W] == SEL_W'(POWERBALL)) && w_blink_phase);
      if ((bus.layer_type[i*SEL_W +: SEL_W] == SEL_W'(EDIBLE_GHOST)) && bus.flash_en
          && w_blink_phase && w_opaque[i])
        w_eff_pix[i*PIX_W +: PIX_W] = PIX_W'(FLASH_PIX);
      if (w_opaque[i]) begin
        w_pac    = w_pac    | (bus.layer_type[i*SEL_W +: SEL_W] == SEL_W'(PACMAN));
        w_ghost  = w_ghost  | (bus.layer_type[i*SEL_W +: SEL_W] == SEL_W'(GHOST));
        w_edible = w_edible | (bus.layer_type[i*SEL_W +: SEL_W] == SEL_W'(EDIBLE_GHOST));
      end
    end
  end

  // Lowest-index opaque layer wins; scan from the bottom so it overwrites last
  always_comb begin
    w_win_pix  = PIX_W'(TRANSPARENT_PIX);
    w_win_type = SEL_W'(SPACE);
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (r_s1_opaque[i]) begin
        w_win_pix  = r_s1_pix[i*PIX_W +: PIX_W];
        w_win_type = r_s1_type[i*SEL_W +: SEL_W];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mask      <= '1;
      r_s1_valid  <= 1'b0;
      r_s1_opaque <= '0;
      r_s1_pix    <= '0;
      r_s1_type   <= '0;
      r_s1_pac    <= 1'b0;
      r_s1_ghost  <= 1'b0;
      r_s1_edible <= 1'b0;
      r_valid_out <= 1'b0;
      r_pix_out   <= '0;
      r_type_out  <= SEL_W'(SPACE);
      r_s2_hit_g  <= 1'b0;
      r_s2_hit_e  <= 1'b0;
      r_acc_g     <= 1'b0;
      r_acc_e     <= 1'b0;
      r_hit_g     <= 1'b0;
      r_hit_e     <= 1'b0;
    end else begin
      if (bus.mask_we)
        r_mask <= bus.mask_wdata;

      r_s1_valid  <= bus.pix_valid_in;
      r_s1_opaque <= w_opaque;
      r_s1_pix    <= w_eff_pix;
      r_s1_type   <= bus.layer_type;
      r_s1_pac    <= w_pac;
      r_s1_ghost  <= w_ghost;
      r_s1_edible <= w_edible;

      r_valid_out <= r_s1_valid;
      r_pix_out   <= r_s1_valid ? w_win_pix : PIX_W'(TRANSPARENT_PIX);
      r_type_out  <= r_s1_valid ? w_win_type : SEL_W'(SPACE);
      r_s2_hit_g  <= r_s1_valid & r_s1_pac & r_s1_ghost;
      r_s2_hit_e  <= r_s1_valid & r_s1_pac & r_s1_edible;

      // The output pixel present on the tick cycle belongs to the frame ending
      if (bus.frame_tick) begin
        r_hit_g <= r_acc_g | r_s2_hit_g;
        r_hit_e <= r_acc_e | r_s2_hit_e;
        r_acc_g <= 1'b0;
        r_acc_e <= 1'b0;
      end else begin
        r_acc_g <= r_acc_g | r_s2_hit_g;
        r_acc_e <= r_acc_e | r_s2_hit_e;
      end
    end
  end

  assign bus.pix_valid_out = r_valid_out;
  assign bus.pix_out       = r_pix_out;
  assign bus.type_out      = r_type_out;
  assign bus.hit_ghost     = r_hit_g;
  assign bus.hit_edible    = r_hit_e;
endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: vector table, directed multi-cycle sequences, random vs. reference model.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned SW = 4;
  localparam int unsigned BF = 16;
  localparam int unsigned FP = 3;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sprite_compositor_if #(.NUM_LAYERS(NL), .PIX_W(PW), .SEL_W(SW)) bus ();

  sprite_compositor #(
    .NUM_LAYERS(NL), .PIX_W(PW), .SEL_W(SW), .BLINK_FRAMES(BF), .FLASH_PIX(FP)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic          v;
    logic [PW-1:0] pix;
    logic [SW-1:0] typ;
    logic          hg;
    logic          he;
  } px_t;

  typedef struct {
    logic [15:0] typ;
    logic [7:0]  pix;
    logic [3:0]  mask;
    int          ep;
    int          et;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;

  int          lt [NL];
  int          lp [NL];
  logic        vin, ft, flash, mwe;
  logic [NL-1:0] mwd;

  int          m_ticks;
  logic [NL-1:0] m_mask;
  px_t         m_s1, m_out;
  logic        m_acc_g, m_acc_e, m_hit_g, m_hit_e;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec-level view of one pixel: first opaque layer in priority order wins
  function automatic px_t ref_px();
    px_t  r;
    logic phase, op, found, pac, gh, ed;
    phase = ((m_ticks / int'(BF)) % 2) == 1;
    r = '{v: vin, pix: '0, typ: '0, hg: 1'b0, he: 1'b0};
    found = 1'b0; pac = 1'b0; gh = 1'b0; ed = 1'b0;
    for (int i = 0; i < int'(NL); i++) begin
      op = m_mask[i] && (lp[i] != 0) && (lt[i] != int'(SPACE))
           && !((lt[i] == int'(POWERBALL)) && phase);
      if (op) begin
        pac = pac | (lt[i] == int'(PACMAN));
        gh  = gh  | (lt[i] == int'(GHOST));
        ed  = ed  | (lt[i] == int'(EDIBLE_GHOST));
        if (!found) begin
          found = 1'b1;
          r.typ = SW'(lt[i]);
          r.pix = (lt[i] == int'(EDIBLE_GHOST) && flash && phase) ? PW'(FP) : PW'(lp[i]);
        end
      end
    end
    if (!vin) begin
      r.pix = '0;
      r.typ = '0;
    end
    r.hg = vin & pac & gh;
    r.he = vin & pac & ed;
    return r;
  endfunction

  task automatic model_reset();
    m_ticks = 0;
    m_mask  = '1;
    m_s1    = '{v: 1'b0, pix: '0, typ: '0, hg: 1'b0, he: 1'b0};
    m_out   = m_s1;
    m_acc_g = 1'b0; m_acc_e = 1'b0;
    m_hit_g = 1'b0; m_hit_e = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},  int'(bus.pix_valid_out), int'(m_out.v));
    chk({tag, ".pix"},    int'(bus.pix_out),       int'(m_out.pix));
    chk({tag, ".type"},   int'(bus.type_out),      int'(m_out.typ));
    chk({tag, ".hit_g"},  int'(bus.hit_ghost),     int'(m_hit_g));
    chk({tag, ".hit_e"},  int'(bus.hit_edible),    int'(m_hit_e));
  endtask

  task automatic set_idle();
    for (int i = 0; i < int'(NL); i++) begin
      lt[i] = 0;
      lp[i] = 0;
    end
    vin = 1'b0; ft = 1'b0; flash = 1'b0; mwe = 1'b0; mwd = '1;
  endtask

  // Drive current inputs, advance model and DUT one clock, then compare
  task automatic cycle(input string tag);
    px_t nxt;
    for (int i = 0; i < int'(NL); i++) begin
      bus.layer_type[i*SW +: SW] = SW'(lt[i]);
      bus.layer_pix[i*PW +: PW]  = PW'(lp[i]);
    end
    bus.pix_valid_in = vin;
    bus.frame_tick   = ft;
    bus.flash_en     = flash;
    bus.mask_we      = mwe;
    bus.mask_wdata   = mwd;
    nxt = ref_px();
    if (ft) begin
      m_hit_g = m_acc_g | m_out.hg;
      m_hit_e = m_acc_e | m_out.he;
      m_acc_g = 1'b0;
      m_acc_e = 1'b0;
      m_ticks++;
    end else begin
      m_acc_g = m_acc_g | m_out.hg;
      m_acc_e = m_acc_e | m_out.he;
    end
    if (mwe) m_mask = mwd;
    m_out = m_s1;
    m_s1  = nxt;
    @(posedge Clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    chk("rst.valid", int'(bus.pix_valid_out), 0);
    chk("rst.hit_g", int'(bus.hit_ghost), 0);
    chk("rst.hit_e", int'(bus.hit_edible), 0);
    chk("rst.pix",   int'(bus.pix_out), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    ft = 1'b1;
    for (int k = 0; k < n; k++) cycle("tick");
    ft = 1'b0;
  endtask

  vec_t vecs [10];

  initial begin
    Reset = 1'b1;
    set_idle();
    for (int i = 0; i < int'(NL); i++) begin
      bus.layer_type[i*SW +: SW] = '0;
      bus.layer_pix[i*PW +: PW]  = '0;
    end
    bus.pix_valid_in = 1'b0; bus.frame_tick = 1'b0; bus.flash_en = 1'b0;
    bus.mask_we = 1'b0; bus.mask_wdata = '1;
    do_reset();
    check_outputs("reset");

    vecs[0] = '{typ: 16'h0058, pix: 8'h06, mask: 4'hF, ep: 2, et: 8};
    vecs[1] = '{typ: 16'h0058, pix: 8'h04, mask: 4'hF, ep: 1, et: 5};
    vecs[2] = '{typ: 16'h0058, pix: 8'h04, mask: 4'hD, ep: 0, et: 0};
    vecs[3] = '{typ: 16'h000C, pix: 8'h03, mask: 4'hF, ep: 3, et: 12};
    vecs[4] = '{typ: 16'h0030, pix: 8'h0B, mask: 4'hF, ep: 2, et: 3};
    vecs[5] = '{typ: 16'h7531, pix: 8'h00, mask: 4'hF, ep: 0, et: 0};
    vecs[6] = '{typ: 16'h7000, pix: 8'h40, mask: 4'hF, ep: 1, et: 7};
    vecs[7] = '{typ: 16'h8888, pix: 8'hFF, mask: 4'h0, ep: 0, et: 0};
    vecs[8] = '{typ: 16'h8888, pix: 8'hFF, mask: 4'h8, ep: 3, et: 8};
    vecs[9] = '{typ: 16'h0082, pix: 8'h09, mask: 4'hF, ep: 1, et: 2};

    // Table vectors at blink phase 0
    for (int v = 0; v < 10; v++) begin
      set_idle();
      mwe = 1'b1; mwd = vecs[v].mask;
      cycle("vmask");
      mwe = 1'b0;
      for (int i = 0; i < int'(NL); i++) begin
        lt[i] = int'(vecs[v].typ[i*4 +: 4]);
        lp[i] = int'(vecs[v].pix[i*2 +: 2]);
      end
      vin = 1'b1;
      cycle("vin");
      chk("vec.early_valid", int'(bus.pix_valid_out), 0);
      set_idle();
      cycle("vlat");
      chk($sformatf("vec%0d.valid", v), int'(bus.pix_valid_out), 1);
      chk($sformatf("vec%0d.pix", v),   int'(bus.pix_out), vecs[v].ep);
      chk($sformatf("vec%0d.type", v),  int'(bus.type_out), vecs[v].et);
      cycle("vidle");
    end

    // Powerball blink: hidden exactly after the 16th tick, back after 32
    do_reset();
    set_idle();
    lt[0] = int'(POWERBALL); lp[0] = 3; vin = 1'b1;
    ticks(15);
    for (int k = 0; k < 3; k++) cycle("pb");
    chk("pb.15", int'(bus.pix_out), 3);
    ticks(1);
    for (int k = 0; k < 3; k++) cycle("pb");
    chk("pb.16", int'(bus.pix_out), 0);
    chk("pb.16type", int'(bus.type_out), int'(SPACE));
    ticks(16);
    for (int k = 0; k < 3; k++) cycle("pb");
    chk("pb.32", int'(bus.pix_out), 3);

    // Frightened ghost flash in blink phase 1
    do_reset();
    set_idle();
    ticks(16);
    lt[0] = int'(EDIBLE_GHOST); lp[0] = 1; vin = 1'b1; flash = 1'b1;
    for (int k = 0; k < 3; k++) cycle("fl");
    chk("flash.on", int'(bus.pix_out), int'(FP));
    flash = 1'b0;
    for (int k = 0; k < 3; k++) cycle("fl");
    chk("flash.off", int'(bus.pix_out), 1);

    // Collision reporting per frame, including a hit coincident with the tick
    do_reset();
    set_idle();
    lt[0] = int'(PACMAN); lp[0] = 1; lt[2] = int'(GHOST); lp[2] = 2; vin = 1'b1;
    cycle("col");
    set_idle();
    for (int k = 0; k < 3; k++) cycle("col");
    ft = 1'b1; cycle("col"); ft = 1'b0;
    chk("col.hit_g", int'(bus.hit_ghost), 1);
    chk("col.hit_e", int'(bus.hit_edible), 0);
    for (int k = 0; k < 4; k++) cycle("col");
    ft = 1'b1; cycle("col"); ft = 1'b0;
    chk("col.clear", int'(bus.hit_ghost), 0);
    lt[1] = int'(PACMAN); lp[1] = 2; lt[3] = int'(EDIBLE_GHOST); lp[3] = 1; vin = 1'b1;
    cycle("col");
    set_idle();
    cycle("col");
    ft = 1'b1; cycle("col"); ft = 1'b0;
    chk("col.coinc_e", int'(bus.hit_edible), 1);
    chk("col.coinc_g", int'(bus.hit_ghost), 0);

    // Reset with pixels in flight and a pending hit flag
    lt[0] = int'(PACMAN); lp[0] = 1; lt[1] = int'(GHOST); lp[1] = 1; vin = 1'b1;
    cycle("fl6");
    cycle("fl6");
    ft = 1'b1; cycle("fl6"); ft = 1'b0;
    chk("pre_rst.hit_g", int'(bus.hit_ghost), 1);
    cycle("fl6");
    do_reset();
    set_idle();
    lt[0] = int'(WALL); lp[0] = 2; vin = 1'b1;
    cycle("post");
    chk("post.lat1", int'(bus.pix_valid_out), 0);
    set_idle();
    cycle("post");
    chk("post.lat2", int'(bus.pix_valid_out), 1);
    chk("post.pix", int'(bus.pix_out), 2);

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < int'(NL); i++) begin
        lt[i] = ($urandom_range(0, 9) < 3) ? (($urandom_range(0, 1) == 1) ? int'(PACMAN) : int'(GHOST))
                                           : int'($urandom_range(0, 15));
        lp[i] = int'($urandom_range(0, 3));
      end
      vin   = ($urandom_range(0, 3) != 0);
      ft    = ($urandom_range(0, 3) == 0);
      flash = ($urandom_range(0, 1) == 1);
      mwe   = ($urandom_range(0, 15) == 0);
      mwd   = NL'($urandom);
      cycle("rnd");
      if (n == 400) begin
        set_idle();
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
